// File: rtl/tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings and the IR all-ones value.
package tap_pkg;

    typedef enum logic [3:0] {
        TLR     = 4'hF,
        RTI     = 4'hC,
        SEL_DR  = 4'h7,
        CAP_DR  = 4'h6,
        SH_DR   = 4'h2,
        EX1_DR  = 4'h1,
        PAU_DR  = 4'h3,
        EX2_DR  = 4'h0,
        UPD_DR  = 4'h5,
        SEL_IR  = 4'h4,
        CAP_IR  = 4'hE,
        SH_IR   = 4'hA,
        EX1_IR  = 4'h9,
        PAU_IR  = 4'hB,
        EX2_IR  = 4'h8,
        UPD_IR  = 4'hD
    } tap_state_t;

    localparam logic [31:0] IR_ALL_ONES = '1;

endpackage

// File: rtl/tap_controller_if.sv
// TAP serial inputs and controller outputs; master = test driver, slave = controller.
interface tap_controller_if #(
    parameter int unsigned IR_WIDTH = 4
) ();

    logic                TMS;
    logic                TDI;
    logic [3:0]          TapState;
    logic                ShiftDR;
    logic                ClockDR;
    logic                UpdateDR;
    logic                ShiftIR;
    logic                ClockIR;
    logic                UpdateIR;
    logic                TestLogicReset;
    logic                Select;
    logic                Enable;
    logic [IR_WIDTH-1:0] Instr;
    logic                IrTDO;
    logic                BypassSel;

    modport master (
        output TMS, TDI,
        input  TapState, ShiftDR, ClockDR, UpdateDR, ShiftIR, ClockIR, UpdateIR,
        input  TestLogicReset, Select, Enable, Instr, IrTDO, BypassSel
    );

    modport slave (
        input  TMS, TDI,
        output TapState, ShiftDR, ClockDR, UpdateDR, ShiftIR, ClockIR, UpdateIR,
        output TestLogicReset, Select, Enable, Instr, IrTDO, BypassSel
    );

endinterface

// File: rtl/tap_instr_reg.sv
// Instruction register: posedge shift stage (capture/shift) and negedge hold stage.
module tap_instr_reg
    import tap_pkg::*;
#(
    parameter int unsigned           IR_WIDTH   = 4,
    parameter logic [IR_WIDTH-1:0]   IR_CAPTURE = IR_WIDTH'(1)
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tdi,
    input  logic                capture,
    input  logic                shift,
    input  logic                update,
    input  logic                reset_hold,
    output logic [IR_WIDTH-1:0] instr,
    output logic                tdo
);

    logic [IR_WIDTH-1:0] shift_reg;

    always_ff @(posedge tck) begin
        if (trst)
            shift_reg <= IR_ALL_ONES[IR_WIDTH-1:0];
        else if (capture)
            shift_reg <= IR_CAPTURE;
        else if (shift)
            shift_reg <= {tdi, shift_reg[IR_WIDTH-1:1]};
    end

    // Hold stage updates half a cycle later so Instr changes only while TCK is low.
    always_ff @(negedge tck) begin
        if (trst || reset_hold)
            instr <= IR_ALL_ONES[IR_WIDTH-1:0];
        else if (update)
            instr <= shift_reg;
    end

    assign tdo = shift_reg[0];

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: state machine, negedge control outputs, gated DR/IR clocks
// and update strobes. Define TAP_INSTR_REG_EN to include instruction register storage.
module tap_controller
    import tap_pkg::*;
#(
    parameter int unsigned           IR_WIDTH   = 4,
    parameter logic [IR_WIDTH-1:0]   IR_CAPTURE = IR_WIDTH'(1)
) (
    input  logic             TCK,
    input  logic             TRST,
    tap_controller_if.slave  tap
);

    tap_state_t state;
    tap_state_t next_state;

    logic shift_dr;
    logic shift_ir;
    logic enable;
    logic tlr;
    logic select;
    logic dr_en;
    logic ir_en;

    always_ff @(posedge TCK) begin
        if (TRST)
            state <= TLR;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            TLR:    next_state = tap.TMS ? TLR    : RTI;
            RTI:    next_state = tap.TMS ? SEL_DR : RTI;
            SEL_DR: next_state = tap.TMS ? SEL_IR : CAP_DR;
            CAP_DR: next_state = tap.TMS ? EX1_DR : SH_DR;
            SH_DR:  next_state = tap.TMS ? EX1_DR : SH_DR;
            EX1_DR: next_state = tap.TMS ? UPD_DR : PAU_DR;
            PAU_DR: next_state = tap.TMS ? EX2_DR : PAU_DR;
            EX2_DR: next_state = tap.TMS ? UPD_DR : SH_DR;
            UPD_DR: next_state = tap.TMS ? SEL_DR : RTI;
            SEL_IR: next_state = tap.TMS ? TLR    : CAP_IR;
            CAP_IR: next_state = tap.TMS ? EX1_IR : SH_IR;
            SH_IR:  next_state = tap.TMS ? EX1_IR : SH_IR;
            EX1_IR: next_state = tap.TMS ? UPD_IR : PAU_IR;
            PAU_IR: next_state = tap.TMS ? EX2_IR : PAU_IR;
            EX2_IR: next_state = tap.TMS ? UPD_IR : SH_IR;
            UPD_IR: next_state = tap.TMS ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

    always_ff @(negedge TCK) begin
        if (TRST) begin
            shift_dr <= 1'b0;
            shift_ir <= 1'b0;
            enable   <= 1'b0;
            tlr      <= 1'b1;
            select   <= 1'b1;
            dr_en    <= 1'b0;
            ir_en    <= 1'b0;
        end else begin
            shift_dr <= (state == SH_DR);
            shift_ir <= (state == SH_IR);
            enable   <= (state == SH_DR) || (state == SH_IR);
            tlr      <= (state == TLR);
            select   <= (state == TLR)    || (state == SEL_IR) || (state == CAP_IR) ||
                        (state == SH_IR)  || (state == EX1_IR) || (state == PAU_IR) ||
                        (state == EX2_IR) || (state == UPD_IR);
            dr_en    <= (state == CAP_DR) || (state == SH_DR);
            ir_en    <= (state == CAP_IR) || (state == SH_IR);
        end
    end

    // Enables change only on negedge, so the gated clocks cannot glitch while TCK is high.
    assign tap.ClockDR  = TCK | ~dr_en;
    assign tap.ClockIR  = TCK | ~ir_en;
    assign tap.UpdateDR = ~TCK & (state == UPD_DR);
    assign tap.UpdateIR = ~TCK & (state == UPD_IR);

    assign tap.TapState       = state;
    assign tap.ShiftDR        = shift_dr;
    assign tap.ShiftIR        = shift_ir;
    assign tap.Enable         = enable;
    assign tap.TestLogicReset = tlr;
    assign tap.Select         = select;

`ifdef TAP_INSTR_REG_EN
    logic [IR_WIDTH-1:0] instr;
    logic                ir_tdo;

    tap_instr_reg #(
        .IR_WIDTH   (IR_WIDTH),
        .IR_CAPTURE (IR_CAPTURE)
    ) u_instr_reg (
        .tck        (TCK),
        .trst       (TRST),
        .tdi        (tap.TDI),
        .capture    (state == CAP_IR),
        .shift      (state == SH_IR),
        .update     (state == UPD_IR),
        .reset_hold (state == TLR),
        .instr      (instr),
        .tdo        (ir_tdo)
    );

    assign tap.Instr     = instr;
    assign tap.IrTDO     = ir_tdo;
    assign tap.BypassSel = &instr;
`else
    logic unused_tdi;
    logic unused_capture;

    assign unused_tdi     = tap.TDI;
    assign unused_capture = ^IR_CAPTURE;
    assign tap.Instr      = IR_ALL_ONES[IR_WIDTH-1:0];
    assign tap.IrTDO      = 1'b0;
    assign tap.BypassSel  = 1'b1;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller; expectations follow TAP_INSTR_REG_EN when defined.
module tb_tap_controller;

    logic tck;
    logic trst;
    int   tests;
    int   fails;
    int   cdr_edges;
    int   cir_edges;
    int   shdr_cycles;
    int   upd_pulses;

    tap_controller_if #(.IR_WIDTH(4)) tif ();

    tap_controller #(
        .IR_WIDTH   (4),
        .IR_CAPTURE (4'b0001)
    ) dut (
        .TCK  (tck),
        .TRST (trst),
        .tap  (tif.slave)
    );

`ifdef TAP_INSTR_REG_EN
    localparam logic [3:0] EXP_SCAN   = 4'b1010;
    localparam logic [3:0] EXP_TDO    = 4'b0001;
    localparam logic       EXP_BYP    = 1'b0;
    localparam logic       EXP_TDO_RS = 1'b1;
`else
    localparam logic [3:0] EXP_SCAN   = 4'b1111;
    localparam logic [3:0] EXP_TDO    = 4'b0000;
    localparam logic       EXP_BYP    = 1'b1;
    localparam logic       EXP_TDO_RS = 1'b0;
`endif

    logic       walk_tms [44] = '{0,0,1,0,1,0,0,1,0,0,1,1,1,0,0,1,0,1,1,0,1,1,
                                  0,1,0,0,1,0,0,1,1,1,1,0,0,1,0,1,1,0,1,1,1,1};
    logic [3:0] walk_st  [44] = '{4'hC,4'hC,4'h7,4'h6,4'h1,4'h3,4'h3,4'h0,4'h2,4'h2,4'h1,
                                  4'h5,4'h7,4'h6,4'h2,4'h1,4'h3,4'h0,4'h5,4'hC,4'h7,4'h4,
                                  4'hE,4'h9,4'hB,4'hB,4'h8,4'hA,4'hA,4'h9,4'hD,4'h7,4'h4,
                                  4'hE,4'hA,4'h9,4'hB,4'h8,4'hD,4'hC,4'h7,4'h4,4'hF,4'hF};

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Only edges aligned with TCK rising count; the enable-drop settling at negedge is ignored.
    always @(posedge tif.ClockDR) if (tck) cdr_edges++;
    always @(posedge tif.ClockIR) if (tck) cir_edges++;
    always @(posedge tck) if (tif.ShiftDR) shdr_cycles++;
    always @(posedge tif.UpdateDR) upd_pulses++;

    task automatic step(input logic tms, input logic tdi);
        tif.TMS = tms;
        tif.TDI = tdi;
        @(posedge tck);
        #1;
    endtask

    task automatic to_neg();
        @(negedge tck);
        #1;
    endtask

    function automatic logic is_ir_col(input logic [3:0] s);
        return s inside {4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD, 4'hF};
    endfunction

    task automatic scan_ir(input logic [3:0] data);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int unsigned i = 0; i < 4; i++) step(i == 3, data[i]);
        step(1, 0); step(0, 0);
    endtask

    task automatic test_reset();
        trst = 1'b1;
        step(0, 0);
        tests++;
        if (tif.TapState !== 4'hF) begin fails++; $display("FAIL reset_state got %h exp F", tif.TapState); end
        to_neg();
        tests++;
        if ({tif.TestLogicReset, tif.Select, tif.Enable, tif.ShiftDR, tif.ShiftIR} !== 5'b11000) begin
            fails++; $display("FAIL reset_ctrl got %b exp 11000",
                {tif.TestLogicReset, tif.Select, tif.Enable, tif.ShiftDR, tif.ShiftIR});
        end
        tests++;
        if (tif.IrTDO !== EXP_TDO_RS) begin fails++; $display("FAIL reset_irtdo got %b exp %b", tif.IrTDO, EXP_TDO_RS); end
        trst = 1'b0;
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        tests++;
        if (tif.TapState !== 4'h2) begin fails++; $display("FAIL reach_shdr got %h exp 2", tif.TapState); end
        trst = 1'b1;
        step(0, 0);
        trst = 1'b0;
        tests++;
        if (tif.TapState !== 4'hF) begin fails++; $display("FAIL trst_shdr_state got %h exp F", tif.TapState); end
        to_neg();
        tests++;
        if (tif.Instr !== 4'hF || tif.BypassSel !== 1'b1 || tif.TestLogicReset !== 1'b1 || tif.ShiftDR !== 1'b0) begin
            fails++; $display("FAIL trst_shdr_out got instr=%h byp=%b tlr=%b sdr=%b exp F 1 1 0",
                tif.Instr, tif.BypassSel, tif.TestLogicReset, tif.ShiftDR);
        end
    endtask

    task automatic test_walk();
        for (int unsigned i = 0; i < 44; i++) begin
            step(walk_tms[i], 0);
            tests++;
            if (tif.TapState !== walk_st[i]) begin
                fails++; $display("FAIL walk_state[%0d] got %h exp %h", i, tif.TapState, walk_st[i]);
            end
            to_neg();
            tests++;
            if (tif.ShiftDR !== (walk_st[i] == 4'h2) || tif.ShiftIR !== (walk_st[i] == 4'hA) ||
                tif.Enable !== (walk_st[i] == 4'h2 || walk_st[i] == 4'hA) ||
                tif.TestLogicReset !== (walk_st[i] == 4'hF) || tif.Select !== is_ir_col(walk_st[i]) ||
                tif.UpdateDR !== (walk_st[i] == 4'h5) || tif.UpdateIR !== (walk_st[i] == 4'hD)) begin
                fails++; $display("FAIL walk_ctrl[%0d] state %h got sdr=%b sir=%b en=%b tlr=%b sel=%b udr=%b uir=%b",
                    i, walk_st[i], tif.ShiftDR, tif.ShiftIR, tif.Enable, tif.TestLogicReset,
                    tif.Select, tif.UpdateDR, tif.UpdateIR);
            end
        end
    endtask

    task automatic test_ir_scan();
        int base_cir;
        logic [3:0] data;
        data = 4'b1010;
        step(0, 0);
        base_cir = cir_edges;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int unsigned i = 0; i < 4; i++) begin
            tests++;
            if (tif.IrTDO !== EXP_TDO[i] || tif.TapState !== 4'hA) begin
                fails++; $display("FAIL ir_tdo[%0d] got %b st %h exp %b st A", i, tif.IrTDO, tif.TapState, EXP_TDO[i]);
            end
            step(i == 3, data[i]);
        end
        step(1, 0);
        tests++;
        if (tif.TapState !== 4'hD) begin fails++; $display("FAIL ir_upd_state got %h exp D", tif.TapState); end
        to_neg();
        tests++;
        if (tif.Instr !== EXP_SCAN || tif.BypassSel !== EXP_BYP) begin
            fails++; $display("FAIL ir_instr got %h byp %b exp %h byp %b", tif.Instr, tif.BypassSel, EXP_SCAN, EXP_BYP);
        end
        step(0, 0);
        tests++;
        if (cir_edges - base_cir !== 5) begin fails++; $display("FAIL ir_clock_edges got %0d exp 5", cir_edges - base_cir); end
    endtask

    task automatic test_five_tms();
        for (int unsigned i = 0; i < 5; i++) step(1, 0);
        tests++;
        if (tif.TapState !== 4'hF) begin fails++; $display("FAIL five_tms_state got %h exp F", tif.TapState); end
        to_neg();
        tests++;
        if (tif.Instr !== 4'hF || tif.TestLogicReset !== 1'b1) begin
            fails++; $display("FAIL five_tms_instr got %h tlr %b exp F 1", tif.Instr, tif.TestLogicReset);
        end
        for (int unsigned i = 0; i < 3; i++) begin
            step(1, 0);
            tests++;
            if (tif.TapState !== 4'hF) begin fails++; $display("FAIL tlr_hold[%0d] got %h exp F", i, tif.TapState); end
        end
        step(0, 0);
    endtask

    task automatic test_dr_path();
        int b_cdr, b_sh, b_upd;
        b_cdr = cdr_edges; b_sh = shdr_cycles; b_upd = upd_pulses;
        step(1, 0); step(0, 0);
        for (int unsigned i = 0; i < 4; i++) step(0, 0);
        tests++;
        if (tif.TapState !== 4'h2) begin fails++; $display("FAIL dr_shift_state got %h exp 2", tif.TapState); end
        step(1, 0); step(1, 0); step(0, 0);
        tests++;
        if (cdr_edges - b_cdr !== 5) begin fails++; $display("FAIL dr_clock_edges got %0d exp 5", cdr_edges - b_cdr); end
        tests++;
        if (shdr_cycles - b_sh !== 4) begin fails++; $display("FAIL dr_shift_cycles got %0d exp 4", shdr_cycles - b_sh); end
        tests++;
        if (upd_pulses - b_upd !== 1) begin fails++; $display("FAIL dr_update_pulses got %0d exp 1", upd_pulses - b_upd); end
    endtask

    task automatic test_pause();
        int b_cdr;
        step(1, 0); step(0, 0); step(0, 0); step(1, 0);
        b_cdr = cdr_edges;
        for (int unsigned i = 0; i < 10; i++) step(0, 0);
        tests++;
        if (tif.TapState !== 4'h3) begin fails++; $display("FAIL pause_state got %h exp 3", tif.TapState); end
        to_neg();
        tests++;
        if (tif.ShiftDR !== 1'b0 || tif.Enable !== 1'b0) begin
            fails++; $display("FAIL pause_ctrl got sdr=%b en=%b exp 0 0", tif.ShiftDR, tif.Enable);
        end
        step(1, 0); step(0, 0);
        tests++;
        if (cdr_edges - b_cdr !== 0 || tif.TapState !== 4'h2) begin
            fails++; $display("FAIL pause_hold got edges=%0d st=%h exp 0 st 2", cdr_edges - b_cdr, tif.TapState);
        end
        to_neg();
        tests++;
        if (tif.ShiftDR !== 1'b1) begin fails++; $display("FAIL pause_resume got sdr=%b exp 1", tif.ShiftDR); end
        step(0, 0);
        tests++;
        if (cdr_edges - b_cdr !== 1) begin fails++; $display("FAIL pause_resume_clk got %0d exp 1", cdr_edges - b_cdr); end
        step(1, 0); step(1, 0); step(0, 0);
    endtask

    task automatic test_trst_midshift();
        scan_ir(4'b1010);
        to_neg();
        tests++;
        if (tif.Instr !== EXP_SCAN) begin fails++; $display("FAIL mid_setup got %h exp %h", tif.Instr, EXP_SCAN); end
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, 0); step(0, 0);
        trst = 1'b1;
        step(0, 0);
        trst = 1'b0;
        tests++;
        if (tif.TapState !== 4'hF || tif.IrTDO !== EXP_TDO_RS) begin
            fails++; $display("FAIL mid_trst_state got %h tdo %b exp F tdo %b", tif.TapState, tif.IrTDO, EXP_TDO_RS);
        end
        to_neg();
        tests++;
        if (tif.Instr !== 4'hF || tif.BypassSel !== 1'b1 || tif.Enable !== 1'b0 || tif.Select !== 1'b1) begin
            fails++; $display("FAIL mid_trst_out got instr=%h byp=%b en=%b sel=%b exp F 1 0 1",
                tif.Instr, tif.BypassSel, tif.Enable, tif.Select);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cdr_edges = 0;
        cir_edges = 0;
        shdr_cycles = 0;
        upd_pulses = 0;
        trst = 1'b1;
        tif.TMS = 1'b1;
        tif.TDI = 1'b0;
        test_reset();
        test_walk();
        test_ir_scan();
        test_five_tms();
        test_dr_path();
        test_pause();
        test_trst_midshift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 Parameter IR_WIDTH, default 4, SHALL set instruction register width (>=2).
REQ-002 Parameter IR_CAPTURE, default 'b0001 (IR_WIDTH bits, LSBs 01), SHALL be the value loaded into the IR shift stage in Capture-IR.
REQ-003 Ports SHALL be:
TCK  in  1  single clock; all sequential elements use it.
TRST  in  1  reset, synchronous, active-high.
TMS  in  1  mode select, sampled on posedge TCK.
TDI  in  1  serial data in (IR path).
TapState  out  4  current FSM state, IEEE 1149.1 encoding.
ShiftDR  out  1  high while in Shift-DR.
ClockDR  out  1  gated clock to data registers.
UpdateDR  out  1  update strobe to data registers.
ShiftIR  out  1  high while in Shift-IR.
ClockIR  out  1  gated clock, IR shift stage.
UpdateIR  out  1  update strobe, IR hold stage.
TestLogicReset  out  1  high while in Test-Logic-Reset.
Select  out  1  0 = DR path, 1 = IR path to TDO mux.
Enable  out  1  TDO driver enable.
Instr  out  IR_WIDTH  current instruction (hold stage).
IrTDO  out  1  IR shift stage LSB.
BypassSel  out  1  high when Instr is all-ones (BYPASS).

Function
REQ-004 FSM SHALL have 16 states, encoded: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
REQ-005 Transitions on posedge TCK (TMS=0 / TMS=1): TLR->RTI/TLR; RTI->RTI/SelDR; SelDR->CapDR/SelIR; CapDR->ShDR/Ex1DR; ShDR->ShDR/Ex1DR; Ex1DR->PauDR/UpdDR; PauDR->PauDR/Ex2DR; Ex2DR->ShDR/UpdDR; UpdDR->RTI/SelDR; SelIR->CapIR/TLR; CapIR->ShIR/Ex1IR; ShIR->ShIR/Ex1IR; Ex1IR->PauIR/UpdIR; PauIR->PauIR/Ex2IR; Ex2IR->ShIR/UpdIR; UpdIR->RTI/SelDR.
REQ-006 Five consecutive TMS=1 posedges SHALL reach TLR from any state.
REQ-007 ShiftDR, ShiftIR, Enable, TestLogicReset, Select SHALL be registered on negedge TCK from TapState; Enable=1 in ShDR or ShIR; Select=1 in any IR-column state (SelIR..UpdIR) and TLR.
REQ-008 ClockDR SHALL equal TCK OR NOT drEn, drEn registered on negedge TCK = (CapDR or ShDR); rising edge coincides with posedge TCK ending those states; no glitch while TCK high.
REQ-009 ClockIR SHALL be formed likewise from (CapIR or ShIR).
REQ-010 UpdateDR SHALL equal (NOT TCK) AND (state==UpdDR); UpdateIR likewise for UpdIR.
REQ-011 IR shift stage SHALL load IR_CAPTURE on posedge TCK leaving CapIR; shift right with TDI into MSB on each posedge TCK leaving ShIR; hold elsewhere.
REQ-012 Instr SHALL load shift stage on negedge TCK in UpdIR; hold elsewhere.
REQ-013 Pause states SHALL hold all shift/hold contents indefinitely.

Reset
REQ-014 TRST=1 at posedge TCK SHALL force TapState=TLR, IR shift stage=all-ones; at negedge: Instr=all-ones, ShiftDR=ShiftIR=Enable=0, TestLogicReset=1, Select=1, drEn/irEn=0.
REQ-015 Entering TLR via TMS SHALL set Instr=all-ones on next negedge, identical to TRST.
REQ-016 TRST mid-shift SHALL abort; partial IR shift SHALL not reach Instr.

Configuration
REQ-017 Macro TAP_INSTR_REG_EN defined: IR shift/hold stages, Instr, IrTDO, BypassSel present per REQ-011..012.
REQ-018 Undefined: no IR storage; Instr=all-ones, IrTDO=0, BypassSel=1 constant; FSM, ClockIR, UpdateIR unchanged.

Structure
REQ-019 Package tap_pkg SHALL hold the 4-bit state typedef with the 16 encodings and IR all-ones constant.
REQ-020 Sub-module tap_instr_reg SHALL implement IR shift and hold stages; FSM and strobe generation stay in tap_controller.

Verification
REQ-021 TRST=1 one cycle from ShDR -> TapState=F, Instr=all-ones, BypassSel=1, TestLogicReset=1 after negedge.
REQ-022 From RTI, TMS 1,1,1,1,1 -> TapState=F after 5th posedge; 3 further TMS=1 -> stays F.
REQ-023 Scan IR: TMS 1,1,0,0, then 3 shifts of TDI with TMS=0 and 4th with TMS=1 (TDI 0,1,0,1 LSB first), TMS 1 -> IrTDO emits 1,0,0,0; Instr=4'b1010 after UpdIR negedge.
REQ-024 DR path RTI->CapDR->ShDR x4->Ex1DR->UpdDR -> ClockDR 5 rising edges aligned to TCK, ShiftDR high exactly 4 negedge-to-negedge periods, one UpdateDR pulse in TCK-low.
REQ-025 Ex1DR->PauDR hold 10 cycles->Ex2DR->ShDR -> no ClockDR edges during pause; shifting resumes.
REQ-026 TAP_INSTR_REG_EN undefined, REQ-023 sequence -> Instr stays all-ones, IrTDO=0, FSM trace identical.
